// File: rtl/pc_fetch_unit_if.sv
// SRAM-like instruction-fetch port between the fetch stage and the AXI bridge.
// The fetch stage is the master: it drives the request and address, the bridge answers.
interface pc_fetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC sequencer: one outstanding fetch at a time, with branch redirects
// applied only after the delay-slot instruction has been consumed by decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_unit_if.master        inst_if,
  input  logic                   PCSrcD,
  input  logic [31:0]            PCBranchD,
  input  logic                   StallF,
  output logic [31:0]            PCF,
  output logic [31:0]            InstrF,
  output logic                   InstrValidF,
  output logic                   AdELF,
  output logic                   FetchBusyF
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_q, instr_d;
  logic        adel_q, adel_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] next_pc_s;
  logic        consume_s;
  logic        req_s;

  // Next sequential PC: a live branch decision beats a latched one, which beats PC+4.
  always_comb begin
    consume_s = (state_q == S_HOLD) && !StallF;
    if (PCSrcD) begin
      next_pc_s = PCBranchD;
    end else if (redir_valid_q) begin
      next_pc_s = redir_pc_q;
    end else begin
      next_pc_s = pcf_q + 32'd4;
    end
  end

  // Fetch sequencing and redirect latching.
  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    instr_d       = instr_q;
    adel_d        = adel_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    req_s         = 1'b0;

    case (state_q)
      S_REQ: begin
        if (pcf_q[1:0] != 2'b00) begin
          instr_d = 32'd0;
          adel_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          req_s = 1'b1;
          if (inst_if.inst_addr_ok) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_WAIT: begin
        if (inst_if.inst_data_ok) begin
          instr_d = inst_if.inst_rdata;
          adel_d  = 1'b0;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!StallF) begin
          pcf_d   = next_pc_s;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Consuming the delay slot retires any pending redirect, so it wins over latching.
    if (consume_s) begin
      redir_valid_d = 1'b0;
    end else if (PCSrcD) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = PCBranchD;
    end else begin
      redir_valid_d = redir_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pcf_q         <= RESET_PC;
      instr_q       <= 32'd0;
      adel_q        <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pcf_q         <= pcf_d;
      instr_q       <= instr_d;
      adel_q        <= adel_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign inst_if.inst_req  = req_s;
  assign inst_if.inst_addr = pcf_q;
  assign PCF               = pcf_q;
  assign InstrF            = instr_q;
  assign AdELF             = adel_q;
  assign InstrValidF       = (state_q == S_HOLD);
  assign FetchBusyF        = (state_q != S_HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a program-order model predicts each consumed
// instruction, a randomized bridge answers fetches, and a monitor compares outputs.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        StallF;
  logic [31:0] PCF, InstrF;
  logic        InstrValidF, AdELF, FetchBusyF;

  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_if    (bus),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .StallF     (StallF),
    .PCF        (PCF),
    .InstrF     (InstrF),
    .InstrValidF(InstrValidF),
    .AdELF      (AdELF),
    .FetchBusyF (FetchBusyF)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          idle = 0;
  int          last_cons = -1;
  bit          mon_en = 1'b0;
  bit          zero_wait = 1'b0;
  bit          br_pending = 1'b0;
  logic [31:0] br_target;
  logic [31:0] cur_target = 32'h8000_0040;
  logic [31:0] model_pc;
  bit          bridge_pend = 1'b0;
  logic [31:0] bridge_addr;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Architectural expectation for the instruction at a given PC.
  function automatic exp_t make_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.adel  = (pc[1:0] != 2'b00);
    e.instr = e.adel ? 32'd0 : mem_word(pc);
    return e;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    int unsigned sel;
    sel = $urandom_range(0, 7);
    r   = $urandom();
    if (sel == 0) return {r[31:2], 2'b10};
    if (sel == 1) return 32'hFFFF_FFF8;
    return 32'h8000_0000 | (r & 32'h0000_FFFC);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc    = RESET_PC;
    exp_q.push_back(make_exp(RESET_PC));
    br_pending  = 1'b0;
    bridge_pend = 1'b0;
    prev_wait   = 1'b0;
    last_cons   = -1;
    idle        = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en           = 1'b0;
    rst              = 1'b1;
    StallF           = 1'b0;
    PCSrcD           = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check32("reset_PCF", PCF, RESET_PC);
    check32("reset_InstrF", InstrF, 32'd0);
    check32("reset_InstrValidF", {31'd0, InstrValidF}, 32'd0);
    check32("reset_AdELF", {31'd0, AdELF}, 32'd0);
    check32("reset_inst_req", {31'd0, bus.inst_req}, 32'd1);
    check32("reset_inst_addr", bus.inst_addr, RESET_PC);
    check32("reset_FetchBusyF", {31'd0, FetchBusyF}, 32'd1);
    mon_en = 1'b1;
  endtask

  // One cycle of stimulus: decode-side controls, model update, bridge response.
  task automatic drive_cycle();
    bit old_pend;
    @(negedge clk);
    cyc++;
    if (zero_wait) begin
      StallF = 1'b0;
      PCSrcD = 1'b0;
    end else begin
      StallF = ($urandom_range(0, 9) < 3);
      PCSrcD = ($urandom_range(0, 9) < 2);
    end
    PCBranchD = cur_target;
    if (PCSrcD) begin
      br_pending = 1'b1;
      br_target  = PCBranchD;
    end
    if (InstrValidF && !StallF) begin
      model_pc   = br_pending ? br_target : model_pc + 32'd4;
      br_pending = 1'b0;
      exp_q.push_back(make_exp(model_pc));
      cur_target = pick_target();
      idle       = 0;
    end else begin
      idle++;
    end

    old_pend         = bridge_pend;
    bus.inst_addr_ok = zero_wait ? 1'b1 : ($urandom_range(0, 1) == 1);
    if (old_pend) begin
      bus.inst_data_ok = zero_wait ? 1'b1 : ($urandom_range(0, 1) == 1);
      bus.inst_rdata   = bus.inst_data_ok ? mem_word(bridge_addr) : $urandom();
      if (bus.inst_data_ok) bridge_pend = 1'b0;
    end else begin
      bus.inst_data_ok = !zero_wait && ($urandom_range(0, 9) == 0);
      bus.inst_rdata   = $urandom();
    end
    if (bus.inst_req && bus.inst_addr_ok) begin
      bridge_pend = 1'b1;
      bridge_addr = bus.inst_addr;
    end
  endtask

  // Monitor: compares fetch-side outputs with the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        if (bus.inst_req) begin
          if (prev_wait) check32("inst_addr_stable", bus.inst_addr, prev_addr);
          if (exp_q.size() > 0) check32("req_addr", bus.inst_addr, exp_q[0].pc);
          prev_wait = !bus.inst_addr_ok;
          prev_addr = bus.inst_addr;
        end else begin
          prev_wait = 1'b0;
        end
        if (InstrValidF) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: InstrValidF=1 with PCF %h, expected no instruction", PCF);
          end else begin
            check32("PCF", PCF, exp_q[0].pc);
            check32("InstrF", InstrF, exp_q[0].instr);
            check32("AdELF", {31'd0, AdELF}, {31'd0, exp_q[0].adel});
            check32("no_prefetch_req", {31'd0, bus.inst_req}, 32'd0);
            check32("FetchBusyF_hold", {31'd0, FetchBusyF}, 32'd0);
            if (!StallF) begin
              void'(exp_q.pop_front());
              if (zero_wait && last_cons >= 0) check32("valid_gap", cyc - last_cons, 32'd3);
              last_cons = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    StallF           = 1'b0;
    PCSrcD           = 1'b0;
    PCBranchD        = 32'd0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'd0;
    br_target        = 32'd0;
    model_pc         = RESET_PC;
    bridge_addr      = 32'd0;
    prev_addr        = 32'd0;

    do_reset();
    zero_wait = 1'b1;
    repeat (20) drive_cycle();
    zero_wait = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      drive_cycle();
      if (idle > 100) begin
        checks++;
        $display("FAIL progress_timeout: %0d idle cycles, expected at most 100", idle);
        break;
      end
    end

    // Abandon an in-flight fetch with a reset while the bridge owes data.
    for (int i = 0; i < 100; i++) begin
      if (bridge_pend) break;
      drive_cycle();
    end
    do_reset();

    for (int i = 0; i < 1000; i++) begin
      drive_cycle();
      if (idle > 100) begin
        checks++;
        $display("FAIL progress_timeout: %0d idle cycles, expected at most 100", idle);
        break;
      end
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage PC sequencer for the five-stage MIPS core: holds PCF, issues one instruction-fetch request at a time on the SRAM-like instruction port in front of the AXI bridge, and presents the returned word to the decode stage. It is the consumer of the decode-stage branch decision (PCSrcD/PCBranchD). It applies redirects after the delay-slot instruction, so the instruction fetched after a taken branch is always the delay slot.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PCF value after reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- PCSrcD  in  1  taken-branch decision from decode; may stay high for several cycles while decode stalls
- PCBranchD  in  32  branch target, valid when PCSrcD=1
- StallF  in  1  fetch output must be held; instruction not consumed this cycle
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address (= PCF)
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  read data
- PCF  out  32  PC of instruction in fetch
- InstrF  out  32  fetched instruction
- InstrValidF  out  1  InstrF/PCF valid for decode
- AdELF  out  1  fetch address error on PCF
- FetchBusyF  out  1  fetch waiting on memory; hazard unit stalls decode-side consumption

## Operation
- One outstanding request max; no prefetch.
- States: S_REQ, S_WAIT, S_HOLD.
- S_REQ: if PCF[1:0]!=0: no request; InstrF<=0, AdELF<=1, go S_HOLD. Else inst_req=1, inst_addr=PCF; on inst_addr_ok go S_WAIT.
- S_WAIT: inst_req=0; on inst_data_ok, InstrF<=inst_rdata, AdELF<=0, go S_HOLD.
- S_HOLD: InstrValidF=1. If StallF=0, the instruction is consumed at this edge: PCF<=next_pc, redir_valid<=0, go S_REQ. If StallF=1, remain; InstrF/PCF/AdELF hold.
- next_pc priority: PCSrcD ? PCBranchD : redir_valid ? redir_pc : PCF+4 (32-bit wrap, carry dropped).
- Redirect latch: any cycle with PCSrcD=1 and no consumption: redir_valid<=1, redir_pc<=PCBranchD. Repeated assertion overwrites with the same value and is idempotent.
- Consumption takes precedence over latching: when PCSrcD=1 and consumption occur in the same cycle, PCBranchD is used directly and redir_valid ends 0.
- inst_data_ok outside S_WAIT and inst_addr_ok outside S_REQ are ignored.
- FetchBusyF = (state != S_HOLD).
- inst_addr is stable while inst_req=1.

## Timing
- Reset: PCF=RESET_PC, state=S_REQ, InstrF=0, InstrValidF=0, AdELF=0, redir_valid=0, redir_pc=0, inst_req=1 in the first cycle after reset release.
- rst mid-request abandons the transaction. The bridge is reset on the same rst, so no stale response occurs.
- Minimum latency with addr_ok in the request cycle and data_ok the next cycle:
  - cycle 0: request accepted
  - cycle 1: data returned
  - cycle 2: InstrValidF=1
  - next request in the cycle after consumption
- Minimum throughput: one instruction per 3 cycles.
- AdEL path: S_REQ to S_HOLD in 1 cycle, and no memory transaction is issued.
- StallF is ignored outside S_HOLD.

## Test plan
- Reset then zero-wait memory (addr_ok same cycle, data_ok next cycle), StallF=0 -> requests 0xBFC00000, 0xBFC00004, 0xBFC00008 in order; each InstrF equals memory contents; InstrValidF pulses every 3rd cycle.
- Branch at 0xBFC00000 with PCSrcD=1 and PCBranchD=0xBFC00100 asserted while the delay-slot fetch of 0xBFC00004 is in S_WAIT -> next requests are 0xBFC00004 then 0xBFC00100; redir_valid clears after the delay slot is consumed.
- PCSrcD=1 in the same cycle the delay slot is consumed in S_HOLD, with PCBranchD=0x80000040 -> next inst_addr=0x80000040 with no intermediate PC+4 request.
- StallF=1 for 5 cycles in S_HOLD with PCSrcD pulsing once (target 0x80001000) -> InstrF/PCF stable for all 5 cycles, no new inst_req; after release, the request goes to 0x80001000.
- Branch target 0x80000002 -> no inst_req for that PC; next cycle InstrValidF=1, AdELF=1, InstrF=0, PCF=0x80000002.
- inst_addr_ok held low for 4 cycles, then a spurious inst_data_ok pulse in S_REQ, then a stall-free reset pulse during S_WAIT -> inst_addr stable while waiting; spurious data ignored; after reset PCF=0xBFC00000 and InstrValidF=0.
